// File: rtl/morse_encoder_pkg.sv
// Shared morse symbol codes, FSM state encoding and default timing for the encoder/decoder path.
package morse_encoder_pkg;

  localparam logic [1:0] MORSE_NONE = 2'b00;
  localparam logic [1:0] MORSE_DOT  = 2'b01;
  localparam logic [1:0] MORSE_LINE = 2'b11;

  localparam int unsigned DEF_UNIT_TICKS = 4;
  localparam int unsigned DEF_DOT_UNITS  = 1;
  localparam int unsigned DEF_LINE_UNITS = 3;
  localparam int unsigned DEF_GAP_UNITS  = 1;
  localparam int unsigned DEF_WORD_UNITS = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MARK  = 3'd2,
    ST_SPACE = 3'd3,
    ST_FIN   = 3'd4
  } morse_state_e;

  // Only dot and line produce a mark; 00 and the illegal 10 both terminate a code.
  function automatic logic is_mark_sym(input logic [1:0] sym);
    return (sym == MORSE_DOT) || (sym == MORSE_LINE);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/morse_tick_timer.sv
// Loadable tick down-counter; expire_c flags the last cycle of the loaded duration.
module morse_tick_timer
  import morse_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire_c = (cnt <= CNT_W'(1));

endmodule

// File: rtl/morse_encoder.sv
// Plays a latched 10-bit morse code (five 2-bit symbols, MSB first) as a timed mark/space signal.
// Optional MORSE_ENCODER_REPEAT_EN: replay the code forever with a word gap between passes.
module morse_encoder
  import morse_encoder_pkg::*;
#(
  parameter int unsigned UNIT_TICKS = DEF_UNIT_TICKS,
  parameter int unsigned DOT_UNITS  = DEF_DOT_UNITS,
  parameter int unsigned LINE_UNITS = DEF_LINE_UNITS,
  parameter int unsigned GAP_UNITS  = DEF_GAP_UNITS,
  parameter int unsigned WORD_UNITS = DEF_WORD_UNITS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] code,
  output logic       signal_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] symbol_idx
);

  localparam int unsigned MAX_TICKS =
    max_u(max_u(LINE_UNITS, WORD_UNITS), max_u(DOT_UNITS, GAP_UNITS)) * UNIT_TICKS;
  localparam int unsigned CNT_W = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] DOT_TICKS  = CNT_W'(DOT_UNITS * UNIT_TICKS);
  localparam logic [CNT_W-1:0] LINE_TICKS = CNT_W'(LINE_UNITS * UNIT_TICKS);
  localparam logic [CNT_W-1:0] GAP_TICKS  = CNT_W'(GAP_UNITS * UNIT_TICKS);
`ifdef MORSE_ENCODER_REPEAT_EN
  localparam logic [CNT_W-1:0] WORD_TICKS = CNT_W'(WORD_UNITS * UNIT_TICKS);
`endif

  morse_state_e     state, state_next;
  logic [9:0]       shreg, shreg_next;
  logic [2:0]       idx_next;
  logic             tmr_load_c;
  logic [CNT_W-1:0] tmr_val_c;
  logic             tmr_expire_c;

`ifdef MORSE_ENCODER_REPEAT_EN
  logic [9:0] code_copy;

  // Copy kept for replay; the shift register is consumed during each pass.
  always_ff @(posedge clock) begin
    if (reset) begin
      code_copy <= '0;
    end else if ((state == ST_IDLE) && start) begin
      code_copy <= code;
    end
  end
`endif

  morse_tick_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (tmr_load_c),
    .load_val(tmr_val_c),
    .expire_c(tmr_expire_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      symbol_idx <= '0;
      signal_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      symbol_idx <= idx_next;
      signal_out <= (state_next == ST_MARK);
      busy       <= (state_next inside {ST_LOAD, ST_MARK, ST_SPACE});
      done       <= (state_next == ST_FIN);
    end
  end

  // Next-state logic; the timer is reloaded on every state change.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    idx_next   = symbol_idx;
    tmr_val_c  = '0;
    tmr_load_c = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          shreg_next = code;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (shreg[9:8] == MORSE_DOT) begin
          state_next = ST_MARK;
          tmr_val_c  = DOT_TICKS;
        end else if (shreg[9:8] == MORSE_LINE) begin
          state_next = ST_MARK;
          tmr_val_c  = LINE_TICKS;
        end else begin
          state_next = ST_FIN;
        end
      end
      ST_MARK: begin
        if (tmr_expire_c) begin
          if ((symbol_idx == 3'd4) || !is_mark_sym(shreg[7:6])) begin
            state_next = ST_FIN;
          end else begin
            state_next = ST_SPACE;
            tmr_val_c  = GAP_TICKS;
            shreg_next = {shreg[7:0], MORSE_NONE};
            idx_next   = symbol_idx + 3'd1;
          end
        end
      end
      ST_SPACE: begin
        if (tmr_expire_c) begin
          state_next = ST_LOAD;
        end
      end
      ST_FIN: begin
        idx_next = '0;
`ifdef MORSE_ENCODER_REPEAT_EN
        state_next = ST_SPACE;
        tmr_val_c  = WORD_TICKS;
        shreg_next = code_copy;
`else
        state_next = ST_IDLE;
`endif
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    tmr_load_c = (state_next != state);
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboard bench for morse_encoder: expected output-change events are queued per playback and
// matched by a negedge monitor against every observed change of signal_out, busy, done, symbol_idx.
module tb_morse_encoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] code  = '0;
  logic       signal_out;
  logic       busy;
  logic       done;
  logic [2:0] symbol_idx;

  morse_encoder dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .code      (code),
    .signal_out(signal_out),
    .busy      (busy),
    .done      (done),
    .symbol_idx(symbol_idx)
  );

  always #5 clock = ~clock;

  localparam int EV_SIG  = 0;
  localparam int EV_BUSY = 1;
  localparam int EV_DONE = 2;
  localparam int EV_IDX  = 3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] off;
    logic [2:0]  val;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fails  = 0;
  int         edge_cnt = 0;
  int         base     = 0;
  int         mon_cyc  = 0;
  bit         mon_en   = 1'b0;
  logic       p_sig    = 1'b0;
  logic       p_busy   = 1'b0;
  logic       p_done   = 1'b0;
  logic [2:0] p_idx    = '0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic push(input int kind, input int off, input int val);
    ev_t e;
    e.kind = 2'(kind);
    e.off  = 16'(off);
    e.val  = 3'(val);
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int off, input int val, input string name);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $display("FAIL %s: unexpected change to %0d at cycle %0d, no event expected", name, val, off);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != 2'(kind) || e.off != 16'(off) || e.val != 3'(val)) begin
        n_fails++;
        $display("FAIL %s: got kind=%0d cycle=%0d value=%0d, expected kind=%0d cycle=%0d value=%0d",
                 name, kind, off, val, e.kind, e.off, e.val);
      end
    end
  endtask

  // Monitor: every output change becomes an event, reported in a fixed per-cycle order.
  always @(negedge clock) begin
    if (mon_en) begin
      mon_cyc = edge_cnt - base;
      if (signal_out !== p_sig)  observe(EV_SIG,  mon_cyc, int'(signal_out), "signal_out");
      if (busy       !== p_busy) observe(EV_BUSY, mon_cyc, int'(busy),       "busy");
      if (done       !== p_done) observe(EV_DONE, mon_cyc, int'(done),       "done");
      if (symbol_idx !== p_idx)  observe(EV_IDX,  mon_cyc, int'(symbol_idx), "symbol_idx");
      p_sig  = signal_out;
      p_busy = busy;
      p_done = done;
      p_idx  = symbol_idx;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic end_check(input string name);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL %s: %0d expected events never seen, next at cycle %0d", name, exp_q.size(),
               exp_q[0].off);
      exp_q.delete();
    end
  endtask

  task automatic wait_to(input int k);
    while ((edge_cnt - base) < k) @(negedge clock);
  endtask

  // Drive start for exactly one cycle; cycle 0 is the cycle start is sampled in.
  task automatic kick(input logic [9:0] c);
    @(negedge clock);
    code  = c;
    start = 1'b1;
    base  = edge_cnt;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic exp_dot_line();
    push(EV_BUSY, 1, 1);
    push(EV_SIG, 2, 1);
    push(EV_SIG, 6, 0);
    push(EV_IDX, 6, 1);
    push(EV_SIG, 11, 1);
    push(EV_SIG, 23, 0);
    push(EV_BUSY, 23, 0);
    push(EV_DONE, 23, 1);
    push(EV_DONE, 24, 0);
    push(EV_IDX, 24, 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("reset signal_out", int'(signal_out), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset symbol_idx", int'(symbol_idx), 0);
    reset = 1'b0;
    @(negedge clock);
    mon_en = 1'b1;

`ifdef MORSE_ENCODER_REPEAT_EN
    // Single dot replayed: 34-cycle period (4 mark + 1 fin + 28 word gap + 1 load).
    push(EV_BUSY, 1, 1);
    for (int p = 0; p < 3; p++) begin
      push(EV_SIG, 2 + 34 * p, 1);
      push(EV_SIG, 6 + 34 * p, 0);
      push(EV_BUSY, 6 + 34 * p, 0);
      push(EV_DONE, 6 + 34 * p, 1);
      push(EV_BUSY, 7 + 34 * p, 1);
      push(EV_DONE, 7 + 34 * p, 0);
    end
    push(EV_BUSY, 79, 0);
    kick(10'b01_00_00_00_00);
    wait_to(20);
    start = 1'b1;
    code  = 10'h3FF;
    wait_to(21);
    start = 1'b0;
    wait_to(78);
    reset = 1'b1;
    wait_to(79);
    reset = 1'b0;
    wait_to(83);
    end_check("repeat");
`else
    exp_dot_line();
    kick(10'b01_11_00_00_00);
    wait_to(28);
    end_check("dot_line");

    push(EV_BUSY, 1, 1);
    push(EV_BUSY, 2, 0);
    push(EV_DONE, 2, 1);
    push(EV_DONE, 3, 0);
    kick(10'b00_01_11_01_01);
    wait_to(6);
    end_check("empty_code");

    // Five 12-cycle lines on a 17-cycle pitch, no trailing gap.
    push(EV_BUSY, 1, 1);
    for (int k = 0; k < 5; k++) begin
      push(EV_SIG, 2 + 17 * k, 1);
      push(EV_SIG, 14 + 17 * k, 0);
      if (k < 4) begin
        push(EV_IDX, 14 + 17 * k, k + 1);
      end else begin
        push(EV_BUSY, 82, 0);
        push(EV_DONE, 82, 1);
      end
    end
    push(EV_DONE, 83, 0);
    push(EV_IDX, 83, 0);
    kick(10'h3FF);
    wait_to(87);
    end_check("five_lines");

    push(EV_BUSY, 1, 1);
    push(EV_SIG, 2, 1);
    push(EV_SIG, 6, 0);
    push(EV_BUSY, 6, 0);
    push(EV_DONE, 6, 1);
    push(EV_DONE, 7, 0);
    kick(10'b01_10_11_00_00);
    wait_to(3);
    start = 1'b1;
    code  = 10'h3FF;
    wait_to(4);
    start = 1'b0;
    wait_to(10);
    end_check("illegal_sym");

    // start held through LOAD and FIN: only accepted again once back in IDLE.
    push(EV_BUSY, 1, 1);
    push(EV_BUSY, 2, 0);
    push(EV_DONE, 2, 1);
    push(EV_DONE, 3, 0);
    push(EV_BUSY, 4, 1);
    push(EV_BUSY, 5, 0);
    push(EV_DONE, 5, 1);
    push(EV_DONE, 6, 0);
    @(negedge clock);
    code  = 10'b00_00_00_00_00;
    start = 1'b1;
    base  = edge_cnt;
    wait_to(4);
    start = 1'b0;
    wait_to(9);
    end_check("start_at_fin");

    push(EV_BUSY, 1, 1);
    push(EV_SIG, 2, 1);
    push(EV_SIG, 6, 0);
    push(EV_IDX, 6, 1);
    push(EV_SIG, 11, 1);
    push(EV_SIG, 17, 0);
    push(EV_BUSY, 17, 0);
    push(EV_IDX, 17, 0);
    kick(10'b01_11_00_00_00);
    wait_to(16);
    reset = 1'b1;
    wait_to(17);
    reset = 1'b0;
    wait_to(20);
    end_check("reset_mid_line");

    exp_dot_line();
    kick(10'b01_11_00_00_00);
    wait_to(28);
    end_check("replay_after_reset");
`endif

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
- Plays a stored 10-bit morse code back as a timed on/off signal for an LED or buzzer. This is the transmit side of the morse path.
- The code is five 2-bit symbols, MSB first: 00 = none, 01 = dot, 11 = line.
- Used to demonstrate player1's code, or to replay a player's code after a round.
- It is the counterpart of the decoder that turns button presses into dot/line strobes.

Parameters:
- UNIT_TICKS, 4, clock cycles per morse time unit (must be ≥1).
- DOT_UNITS, 1, mark length of a dot, in units.
- LINE_UNITS, 3, mark length of a line, in units.
- GAP_UNITS, 1, space length between symbols, in units.
- WORD_UNITS, 7, space before a repeat (used only with the optional feature).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin playback; sampled only in IDLE.
- code  input  10  five symbols; [9:8] is played first.
- signal_out  output  1  registered morse output; 1 = mark.
- busy  output  1  high while playback is in progress.
- done  output  1  one-cycle pulse when playback finishes.
- symbol_idx  output  3  index (0-4) of the symbol currently playing.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high, named reset; the clock is named clock.
- Reset values:
  - signal_out=0, busy=0, done=0, symbol_idx=0.
  - State = IDLE; shift register = 0; counters = 0.
- Reset mid-playback: all outputs return to their reset values on the next edge, and any partial playback is abandoned.
- FSM states: IDLE, LOAD, MARK, SPACE, FIN.
- IDLE:
  - If start=1, latch code into a 10-bit shift register and go to LOAD.
  - code is not sampled again until the next start.
- LOAD:
  - busy=1.
  - Examine shreg[9:8]:
    - 01: go to MARK with a duration of DOT_UNITS*UNIT_TICKS cycles.
    - 11: go to MARK with a duration of LINE_UNITS*UNIT_TICKS cycles.
    - 00 or 10: end of code; go to FIN. The 10 symbol is illegal and is treated as the terminator.
- MARK:
  - signal_out=1 for exactly the loaded duration in cycles.
  - At expiry:
    - If symbol_idx=4, or the next symbol (shreg[7:6]) is 00 or 10: go to FIN. There is no trailing gap.
    - Otherwise: shift the register left by 2, increment symbol_idx, and go to SPACE.
- SPACE: signal_out=0 for GAP_UNITS*UNIT_TICKS cycles, then go to LOAD.
- FIN:
  - done=1 and busy=0 for one cycle, then go to IDLE.
  - symbol_idx returns to 0 on the FIN→IDLE transition.
- Latency:
  - start is seen at cycle 0; LOAD is cycle 1; the first mark cycle is cycle 2.
  - Each LOAD costs one extra cycle with signal_out=0, appended to the preceding gap.
- Symbols after the first 00/10 are never played, even if they are nonzero.
- start while busy is ignored.
- start asserted in the same cycle as the FIN pulse is ignored; it is accepted from IDLE on the next cycle.
- Timing base: one down-counter in ticks, reloaded on every state entry. There is no separate unit prescaler, so duration accuracy is exact to the cycle.
- Counter width: the counter must be wide enough to hold max(LINE_UNITS, WORD_UNITS)*UNIT_TICKS.

Optional Feature:
- Macro: MORSE_ENCODER_REPEAT_EN.
- When defined:
  - FIN does not return to IDLE. Instead, after the done pulse, the block spaces for WORD_UNITS*UNIT_TICKS cycles with busy=1.
  - It then reloads the latched copy of code and replays it.
  - Playback repeats until reset.
  - start remains ignored while repeating.
  - done pulses once per pass.
- When undefined: single-shot playback. The WORD_UNITS parameter is unused and no latched copy register is built.

Decomposition:
- Shared include morse_defs.vh holds:
  - MORSE_NONE=2'b00, MORSE_DOT=2'b01, MORSE_LINE=2'b11;
  - the FSM state encodings;
  - default unit counts.
- The decoder/checker side uses the same include.
- One sub-module, morse_tick_timer: a loadable down-counter with a load value input and an expire strobe. It is reused for MARK, SPACE and word-gap timing.

Test Plan (all with UNIT_TICKS=4 unless stated):
- Dot, line: code=10'b01_11_00_00_00, start at cycle 0 → signal_out high in cycles 2-5, low 6-10, high 11-22; done=1 at cycle 23; busy high 1-22.
- Empty code: code=10'b00_01_11_01_01 → no mark ever; done=1 at cycle 2; busy=1 only at cycle 1.
- Full five lines: code=10'h3FF → five 12-cycle marks separated by 5-cycle lows; symbol_idx steps 0→4; single done pulse; no trailing gap.
- Illegal and ignored inputs: code=10'b01_10_11_00_00 → exactly one 4-cycle dot, then done. Pulsing start mid-mark is ignored, and changing code mid-playback has no effect.
- Reset mid-line: assert reset during the 6th mark cycle → next cycle signal_out=0, busy=0, done=0. A later start replays from symbol 0.
- With MORSE_ENCODER_REPEAT_EN, code=10'b01_00_00_00_00 → marks at cycles 2-5, done at 6, word gap of 28 cycles, then the next mark begins after the word gap plus one LOAD cycle. This repeats 3 times with 3 done pulses.
